// File: rtl/wb_commit_buffer_pkg.sv
// ---------------------------------------------------------------------------
// wb_commit_buffer_pkg
// Shared core types for the writeback commit path.
//   execute_signals_t : registered execute-stage result handed to writeback
//   wb_entry_t        : what the commit buffer keeps per instruction
//   WB_DEPTH_DEFAULT  : default commit buffer depth
// ---------------------------------------------------------------------------
package wb_commit_buffer_pkg;

   localparam int unsigned WB_DEPTH_DEFAULT = 8;
   localparam int unsigned XLEN             = 32;
   localparam int unsigned REG_AW           = 5;

   // Execute-stage result, one per issue pipe
   typedef struct packed {
      logic              valid;
      logic [31:0]       inst;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic [XLEN-1:0]   result;
      logic [XLEN-1:0]   pc;
   } execute_signals_t;

   // Commit buffer entry; the instruction word is not needed past execute
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic [XLEN-1:0]   result;
      logic [XLEN-1:0]   pc;
   } wb_entry_t;

endpackage : wb_commit_buffer_pkg

// File: rtl/wb_commit_buffer_fifo.sv
// ---------------------------------------------------------------------------
// commit_fifo
// Dual-write / dual-read circular queue. Up to two elements are pushed and
// up to two popped per cycle; the two oldest elements are always visible.
// Pointers carry one extra wrap bit so full (count==DEPTH) and empty
// (count==0) are distinguishable without a separate flag.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push_cnt_i  : number of elements pushed this cycle (0..2)
//   wdata0_i    : first (older) pushed element
//   wdata1_i    : second (younger) pushed element, used when push_cnt_i==2
//   pop_cnt_i   : number of elements popped this cycle (0..2)
//   rdata0_o    : element at head
//   rdata1_o    : element at head+1
//   count_o     : current occupancy
// The caller guarantees no overflow/underflow.
// ---------------------------------------------------------------------------
module commit_fifo
   import wb_commit_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
   parameter type         T     = wb_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             push_cnt_i,
   input  T                       wdata0_i,
   input  T                       wdata1_i,
   input  logic [1:0]             pop_cnt_i,
   output T                       rdata0_o,
   output T                       rdata1_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [AW-1:0] head_idx, head_nxt_idx;
   logic [AW-1:0] tail_idx, tail_nxt_idx;

   T mem_q [DEPTH];

   // Storage indices and next-state pointers
   always_comb begin
      head_idx     = head_q[AW-1:0];
      tail_idx     = tail_q[AW-1:0];
      head_nxt_idx = head_idx + AW'(1);
      tail_nxt_idx = tail_idx + AW'(1);
      head_d       = head_q + PW'(pop_cnt_i);
      tail_d       = tail_q + PW'(push_cnt_i);
   end

   // Pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Storage array; contents are don't-care until pushed, so no reset
   always_ff @(posedge clk) begin
      if (push_cnt_i != 2'd0) begin
         mem_q[tail_idx] <= wdata0_i;
      end
      if (push_cnt_i == 2'd2) begin
         mem_q[tail_nxt_idx] <= wdata1_i;
      end
   end

   assign rdata0_o = mem_q[head_idx];
   assign rdata1_o = mem_q[head_nxt_idx];

   // Wrap bit makes the plain difference the occupancy
   assign count_o  = tail_q - head_q;

endmodule : commit_fifo

// File: rtl/wb_commit_buffer.sv
// ---------------------------------------------------------------------------
// wb_commit_buffer
// Writeback commit buffer for the dual-issue core. Takes registered execute
// results from pipe A (older) and pipe B (younger), queues them in program
// order and retires up to two per cycle into the register file. RF write
// port 1 is shared with the LSU, which has priority on it.
//
// Optional feature macro: WB_RETIRE_STATS_EN adds the saturating 64-bit
// retired-instruction counter and its instret port.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   ex_a, ex_b            : execute results, A older than B
//   kill_b                : discard ex_b this cycle (pipe A redirect)
//   in_ready              : at least two free entries (combinational)
//   lsu_wr_en             : LSU owns RF write port 1 this cycle
//   wr0_en/addr/data      : RF write port 0 (combinational from head)
//   wr1_en/addr/data      : RF write port 1 (combinational from head+1)
//   count                 : current occupancy
//   instret               : retired-instruction counter (macro only)
// ---------------------------------------------------------------------------
module wb_commit_buffer
   import wb_commit_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  execute_signals_t       ex_a,
   input  execute_signals_t       ex_b,
   input  logic                   kill_b,
   output logic                   in_ready,
   input  logic                   lsu_wr_en,
   output logic                   wr0_en,
   output logic [4:0]             wr0_addr,
   output logic [31:0]            wr0_data,
   output logic                   wr1_en,
   output logic [4:0]             wr1_addr,
   output logic [31:0]            wr1_data,
   output logic [$clog2(DEPTH):0] count
`ifdef WB_RETIRE_STATS_EN
   ,
   output logic [63:0]            instret
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic       acc_a, acc_b;
   logic [1:0] push_cnt, pop_cnt;
   wb_entry_t  ent_a, ent_b, wdata0, wdata1;
   wb_entry_t  slot0, slot1;
   logic       ret0, ret1;
   logic       we0, we1, waw;
   logic       unused_fields;

   // Space for a full dual-issue group, from registered occupancy only
   always_comb begin
      in_ready = (CW'(DEPTH) - count) >= CW'(2);
   end

   // Lane acceptance and packing; a lone B lands in the first write slot
   always_comb begin
      acc_a     = 1'b0;
      acc_b     = 1'b0;
      push_cnt  = 2'd0;
      ent_a     = '0;
      ent_b     = '0;
      wdata0    = '0;
      wdata1    = '0;

      ent_a.rd        = ex_a.rd;
      ent_a.reg_write = ex_a.reg_write;
      ent_a.result    = ex_a.result;
      ent_a.pc        = ex_a.pc;
      ent_b.rd        = ex_b.rd;
      ent_b.reg_write = ex_b.reg_write;
      ent_b.result    = ex_b.result;
      ent_b.pc        = ex_b.pc;

      acc_a    = ex_a.valid && in_ready;
      acc_b    = ex_b.valid && !kill_b && in_ready;
      push_cnt = {1'b0, acc_a} + {1'b0, acc_b};
      wdata0   = acc_a ? ent_a : ent_b;
      wdata1   = ent_b;
   end

   commit_fifo #(
      .DEPTH (DEPTH),
      .T     (wb_entry_t)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_cnt_i (push_cnt),
      .wdata0_i   (wdata0),
      .wdata1_i   (wdata1),
      .pop_cnt_i  (pop_cnt),
      .rdata0_o   (slot0),
      .rdata1_o   (slot1),
      .count_o    (count)
   );

   // Retire selection: head always goes, head+1 only if port 1 is free
   always_comb begin
      ret0    = 1'b0;
      ret1    = 1'b0;
      pop_cnt = 2'd0;

      ret0    = count != CW'(0);
      ret1    = (count >= CW'(2)) && !lsu_wr_en;
      pop_cnt = {1'b0, ret0} + {1'b0, ret1};
   end

   // RF writes; on a same-rd pair only the younger value lands
   always_comb begin
      we0      = 1'b0;
      we1      = 1'b0;
      waw      = 1'b0;
      wr0_en   = 1'b0;
      wr1_en   = 1'b0;

      we0      = ret0 && slot0.reg_write && (slot0.rd != 5'd0);
      we1      = ret1 && slot1.reg_write && (slot1.rd != 5'd0);
      waw      = we0 && we1 && (slot0.rd == slot1.rd);
      wr0_en   = we0 && !waw;
      wr1_en   = we1;
   end

   assign wr0_addr = slot0.rd;
   assign wr0_data = slot0.result;
   assign wr1_addr = slot1.rd;
   assign wr1_data = slot1.result;

   // Fields carried for debug/trace but not consumed here
   assign unused_fields = ^{ex_a.inst, ex_b.inst, slot0.pc, slot1.pc};

`ifdef WB_RETIRE_STATS_EN
   logic [63:0] instret_q, instret_d;
   logic [64:0] instret_sum;

   // Saturating add of this cycle's retire count
   always_comb begin
      instret_sum = {1'b0, instret_q} + 65'(pop_cnt);
      instret_d   = instret_sum[64] ? '1 : instret_sum[63:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`endif

endmodule : wb_commit_buffer

// File: tb/tb_wb_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_buffer
// Scoreboard bench: the driver pushes each accepted entry into an in-order
// expected queue; a monitor, once per cycle, predicts which queue entries
// retire and what the RF ports should show, compares, then pops them.
// ---------------------------------------------------------------------------
module tb_wb_commit_buffer;
   import wb_commit_buffer_pkg::*;

   localparam int unsigned DEPTH = WB_DEPTH_DEFAULT;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   execute_signals_t ex_a, ex_b;
   logic             kill_b, lsu_wr_en;
   logic             in_ready;
   logic             wr0_en, wr1_en;
   logic [4:0]       wr0_addr, wr1_addr;
   logic [31:0]      wr0_data, wr1_data;
   logic [CW-1:0]    count;
`ifdef WB_RETIRE_STATS_EN
   logic [63:0]      instret;
   longint unsigned  m_instret = 0;
`endif

   wb_entry_t exp_q[$];
   int        errors = 0;
   int        checks = 0;

   always #5 clk = ~clk;

   wb_commit_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .ex_a      (ex_a),
      .ex_b      (ex_b),
      .kill_b    (kill_b),
      .in_ready  (in_ready),
      .lsu_wr_en (lsu_wr_en),
      .wr0_en    (wr0_en),
      .wr0_addr  (wr0_addr),
      .wr0_data  (wr0_data),
      .wr1_en    (wr1_en),
      .wr1_addr  (wr1_addr),
      .wr1_data  (wr1_data),
      .count     (count)
`ifdef WB_RETIRE_STATS_EN
      ,
      .instret   (instret)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol: no lane may be presented while the buffer is not ready
   always @(posedge clk) begin
      if (!reset) begin
         assert (in_ready || !(ex_a.valid || ex_b.valid))
         else begin
            errors++;
            $error("FAIL protocol: lane presented with in_ready=0");
         end
      end
   end

   // Monitor: predict this cycle's retirement from the expected queue
   task automatic monitor_step();
      int        n, nret;
      wb_entry_t e0, e1;
      logic      w0, w1;
      n = exp_q.size();
      check("count", 64'(count), 64'(n));
      check("in_ready", 64'(in_ready), 64'((int'(DEPTH) - n) >= 2));
`ifdef WB_RETIRE_STATS_EN
      check("instret", instret, m_instret);
`endif
      if (reset) begin
         check("wr0_en_reset", 64'(wr0_en), 64'(0));
         check("wr1_en_reset", 64'(wr1_en), 64'(0));
         return;
      end
      nret = (n == 0) ? 0 : ((n >= 2 && !lsu_wr_en) ? 2 : 1);
      w0 = 1'b0;
      w1 = 1'b0;
      e0 = '0;
      e1 = '0;
      if (nret >= 1) begin
         e0 = exp_q[0];
         w0 = e0.reg_write && (e0.rd != 5'd0);
      end
      if (nret == 2) begin
         e1 = exp_q[1];
         w1 = e1.reg_write && (e1.rd != 5'd0);
         if (w0 && w1 && e0.rd == e1.rd) w0 = 1'b0;
      end
      check("wr0_en", 64'(wr0_en), 64'(w0));
      check("wr1_en", 64'(wr1_en), 64'(w1));
      if (w0) begin
         check("wr0_addr", 64'(wr0_addr), 64'(e0.rd));
         check("wr0_data", 64'(wr0_data), 64'(e0.result));
      end
      if (w1) begin
         check("wr1_addr", 64'(wr1_addr), 64'(e1.rd));
         check("wr1_data", 64'(wr1_data), 64'(e1.result));
      end
`ifdef WB_RETIRE_STATS_EN
      m_instret = m_instret + longint'(nret);
`endif
      repeat (nret) void'(exp_q.pop_front());
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #3;
         monitor_step();
      end
   end

   // One cycle of stimulus; lanes are offered only when the model has room
   task automatic drive(input logic av, input logic [4:0] ard, input logic arw, input logic [31:0] ares,
                        input logic bv, input logic [4:0] brd, input logic brw, input logic [31:0] bres,
                        input logic kb, input logic lsu);
      logic      ok;
      wb_entry_t e;
      @(negedge clk);
      #1;
      ok = (int'(DEPTH) - exp_q.size()) >= 2;
      ex_a.valid     = av && ok;
      ex_a.inst      = 32'($urandom);
      ex_a.rd        = ard;
      ex_a.reg_write = arw;
      ex_a.result    = ares;
      ex_a.pc        = 32'($urandom);
      ex_b.valid     = bv && ok;
      ex_b.inst      = 32'($urandom);
      ex_b.rd        = brd;
      ex_b.reg_write = brw;
      ex_b.result    = bres;
      ex_b.pc        = 32'($urandom);
      kill_b         = kb;
      lsu_wr_en      = lsu;
      @(posedge clk);
      #1;
      if (ex_a.valid) begin
         e = '{rd: ex_a.rd, reg_write: ex_a.reg_write, result: ex_a.result, pc: ex_a.pc};
         exp_q.push_back(e);
      end
      if (ex_b.valid && !kill_b) begin
         e = '{rd: ex_b.rd, reg_write: ex_b.reg_write, result: ex_b.result, pc: ex_b.pc};
         exp_q.push_back(e);
      end
      ex_a.valid = 1'b0;
      ex_b.valid = 1'b0;
   endtask

   task automatic idle(input int cycles, input logic lsu);
      repeat (cycles) drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, lsu);
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      #1;
      reset      = 1'b1;
      ex_a.valid = 1'b0;
      ex_b.valid = 1'b0;
      exp_q.delete();
`ifdef WB_RETIRE_STATS_EN
      m_instret = 0;
`endif
      repeat (cycles) @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      ex_a      = '0;
      ex_b      = '0;
      kill_b    = 1'b0;
      lsu_wr_en = 1'b0;
      #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;
      idle(2, 1'b0);

      // Single A result
      drive(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      idle(2, 1'b0);

      // Same-rd pair retiring together
      drive(1'b1, 5'd3, 1'b1, 32'hA, 1'b1, 5'd3, 1'b1, 32'hB, 1'b0, 1'b0);
      idle(2, 1'b0);

      // Fill with port 1 held by the LSU, then drain one per cycle
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'(i + 1), 1'b1, 32'h100 + 32'(i), 1'b1, 5'(i + 10), 1'b1, 32'h200 + 32'(i), 1'b0, 1'b1);
      end
      idle(10, 1'b1);

      // kill_b drops the younger lane only
      drive(1'b1, 5'd7, 1'b1, 32'hC0DE, 1'b1, 5'd8, 1'b1, 32'hDEAD, 1'b1, 1'b0);
      idle(2, 1'b0);

      // x0 destination still retires without a write
      drive(1'b1, 5'd0, 1'b1, 32'h5555, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 5'd9, 1'b0, 32'h6666, 1'b1, 5'd0, 1'b1, 32'h7777, 1'b0, 1'b0);
      idle(2, 1'b0);

      // Reset with entries in flight
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(i + 20), 1'b1, 32'hF00 + 32'(i), 1'b1, 5'(i + 24), 1'b1, 32'hE00 + 32'(i), 1'b0, 1'b1);
      end
      apply_reset(2);
      idle(4, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0, $urandom,
               $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0, $urandom,
               $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      end
      idle(12, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_wb_commit_buffer

// File: doc/wb_commit_buffer.md
# wb_commit_buffer

Writeback commit buffer for the dual-issue core. Accepts registered execute results from pipe A (older) and pipe B (younger) and holds them in a small in-order queue. Retires up to two per cycle into the register file, sharing write port 1 with the load/store unit. It is the consumer end of the execute_signals_t interface and the only writer of architectural integer state apart from the LSU.

## Interface
- DEPTH, 8: queue entries; power of two, at least 4.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ex_a  in  execute_signals_t  pipe A result (older in program order)
- ex_b  in  execute_signals_t  pipe B result (younger)
- kill_b  in  1  discard ex_b this cycle (pipe A redirect)
- in_ready  out  1  at least 2 free entries; issue stalls when low
- lsu_wr_en  in  1  LSU claims RF write port 1 this cycle
- wr0_en / wr0_addr / wr0_data  out  1/5/32  RF write port 0
- wr1_en / wr1_addr / wr1_data  out  1/5/32  RF write port 1, valid only when lsu_wr_en=0
- count  out  $clog2(DEPTH)+1  current occupancy
- instret  out  64  retired-instruction counter; present only with WB_RETIRE_STATS_EN

## Operation
- Enqueue: a lane is accepted when its valid is set, in_ready=1 and, for B only, kill_b=0. A is written before B.
  - 0, 1 or 2 entries per cycle.
  - Tail advances by the number accepted, modulo DEPTH.
  - Lanes presented with in_ready=0 are dropped and counted as a protocol error. No internal state changes; the bench flags it with an assertion.
- Stored entry (wb_entry_t): rd, reg_write, result, pc. inst is not stored.
- Retire, head-first, in order:
  - Slot 0 is the head. It retires whenever count≥1.
  - Slot 1 is head+1. It retires when count≥2 and lsu_wr_en=0.
  - Head advances by the number retired.
- Write enable: wrN_en = reg_write && rd≠0. Entries with rd=0 or reg_write=0 still retire and consume a slot.
- WAW suppression: if both slots retire with the same nonzero rd, wr0_en is forced 0 and only slot 1 (the younger) writes.
- Simultaneous enqueue and retire in one cycle: count_next = count + accepted − retired. An entry enqueued this cycle is never retired in the same cycle.
- Full/empty: count==DEPTH is full, count==0 is empty. Pointers carry one extra wrap bit.
- in_ready = (DEPTH − count) ≥ 2, computed combinationally from the registered count.

## Timing
- Latency: an entry enqueued at edge N drives wr0/wr1 combinationally during cycle N+1, at the earliest.
- The RF samples writes at edge N+2.
- Throughput: 2 per cycle sustained when lsu_wr_en=0; 1 per cycle when lsu_wr_en is held high.
- Reset (async): head=tail=0, count=0, instret=0.
  - All wr*_en are 0 while reset is asserted.
  - in_ready=1 from the first cycle after deassertion.
  - Contents in flight at reset are discarded and never written.
- Outputs wr* are combinational from head state and lsu_wr_en. There is no same-cycle path from ex_a/ex_b to wr*.

## Configuration
- WB_RETIRE_STATS_EN defined: instret port exists and increments by the number retired each cycle (0/1/2). It saturates at all-ones.
- WB_RETIRE_STATS_EN undefined: instret port and counter are absent. All other behaviour is identical.

## Structure
- Shared core package holds:
  - wb_entry_t typedef (rd[4:0], reg_write, result[31:0], pc[31:0]).
  - WB_DEPTH_DEFAULT constant.
  - execute_signals_t, which already lives there.
- Sub-module commit_fifo: a dual-write, dual-read circular storage array with pointer/count logic, parameterised by DEPTH and element type.
- The top level holds lane acceptance, WAW suppression, port-1 arbitration and the stats counter.

## Test plan
- Single A result rd=5, result=0x1234 → next cycle wr0_en=1, wr0_addr=5, wr0_data=0x1234; count returns to 0.
- A rd=3=0xA and B rd=3=0xB in the same cycle, lsu_wr_en=0 → wr0_en=0; wr1_en=1 writing x3=0xB.
- Fill to DEPTH−1 with lsu_wr_en held high → in_ready=0 at count≥7 (DEPTH=8); entries drain 1 per cycle through port 0 in order.
- kill_b=1 with both lanes valid → only A is enqueued; count increments by 1.
- Result with rd=0, reg_write=1 → retires with wr0_en=0; with the macro defined, instret still increments.
- Reset asserted while count=5 → wr*_en=0 immediately; after release count=0, in_ready=1, and no stale writes appear.
